// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 32 x 64-bit register file.
// X31 (XZR) is never stored; it reads as a constant zero.
package regfile_pkg;

  localparam int WORD_W   = 64;
  localparam int NUM_REGS = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [4:0]        regidx_t;

  localparam regidx_t XZR_IDX = 5'd31;

endpackage

// File: rtl/regfile_dec.sv
// 5:32 one-hot write-enable decoder, built from a 2:4 stage feeding four 3:8 stages
// so the leaf decoders can be reused elsewhere in the core.
module dec2_4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end
endmodule

module dec3_8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end
endmodule

module decoder5_32
  import regfile_pkg::*;
(
  input  regidx_t     idx,
  input  logic        en,
  output logic [31:0] y
);
  logic [3:0] grp_en;

  dec2_4 u_hi (
    .en  (en),
    .sel (idx[4:3]),
    .y   (grp_en)
  );

  // Each upper-stage output enables one bank of eight registers.
  for (genvar g = 0; g < 4; g++) begin : g_lo
    dec3_8 u_lo (
      .en  (grp_en[g]),
      .sel (idx[2:0]),
      .y   (y[g*8 +: 8])
    );
  end
endmodule

// File: rtl/regfile_mux.sv
// 64-bit 32:1 read multiplexer; one instance per read port.
module mux32_64
  import regfile_pkg::*;
(
  input  word_t [NUM_REGS-1:0] din,
  input  regidx_t              sel,
  output word_t                dout
);
  always_comb begin
    dout = din[sel];
  end
endmodule

// File: rtl/regfile_reg.sv
// 64-bit enabled storage register with synchronous active-high clear.
module en_reg64
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  word_t d,
  output word_t q
);
  word_t q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // Reset is tested first so an unknown enable cannot leak into the register.
  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/regfile.sv
// 32 x 64-bit register file, one write port and two combinational read ports.
// Optional same-cycle write-through bypass when REGFILE_BYPASS_EN is defined.
module regfile
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    RegWrite,
  input  regidx_t WriteRegister,
  input  word_t   WriteData,
  input  regidx_t ReadRegister1,
  input  regidx_t ReadRegister2,
  output word_t   ReadData1,
  output word_t   ReadData2
);
  logic [31:0]          wr_en;
  logic                 unused_xzr_en;
  word_t                x_q [NUM_REGS-1];
  word_t [NUM_REGS-1:0] rd_bus;
  word_t                mux1, mux2;

  decoder5_32 u_dec (
    .idx (WriteRegister),
    .en  (RegWrite),
    .y   (wr_en)
  );

  assign unused_xzr_en = wr_en[XZR_IDX];

  for (genvar i = 0; i < NUM_REGS-1; i++) begin : g_reg
    en_reg64 u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en[i]),
      .d     (WriteData),
      .q     (x_q[i])
    );
  end

  always_comb begin
    rd_bus = '0;
    for (int i = 0; i < NUM_REGS-1; i++) rd_bus[i] = x_q[i];
  end

  mux32_64 u_rd1 (.din(rd_bus), .sel(ReadRegister1), .dout(mux1));
  mux32_64 u_rd2 (.din(rd_bus), .sel(ReadRegister2), .dout(mux2));

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;

  always_comb begin
    byp_ok    = RegWrite && !reset && (WriteRegister != XZR_IDX);
    ReadData1 = mux1;
    ReadData2 = mux2;
    if (byp_ok && ReadRegister1 == WriteRegister) ReadData1 = WriteData;
    if (byp_ok && ReadRegister2 == WriteRegister) ReadData2 = WriteData;
  end
`else
  always_comb begin
    ReadData1 = mux1;
    ReadData2 = mux2;
  end
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: vector table plus hand sequences, scoreboard-ordered checks.
module tb_regfile;
  import regfile_pkg::*;

  logic    clk = 1'b0;
  logic    reset;
  logic    RegWrite;
  regidx_t WriteRegister;
  word_t   WriteData;
  regidx_t ReadRegister1;
  regidx_t ReadRegister2;
  word_t   ReadData1;
  word_t   ReadData2;

  regfile dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam word_t K = 64'h1111_1111_1111_1111;

  typedef struct {
    logic    rw;
    regidx_t wa;
    word_t   wd;
    regidx_t ra1;
    regidx_t ra2;
    word_t   e1;
    word_t   e2;
  } vec_t;

  typedef struct {
    string name;
    word_t e1;
    word_t e2;
  } exp_t;

  exp_t  sb[$];
  word_t model [NUM_REGS];
  vec_t  vecs [9];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic cmp(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive read indices, queue the expectation, then sample mid-cycle and retire it.
  task automatic rd(input string name, input regidx_t a1, input regidx_t a2,
                    input word_t e1, input word_t e2);
    exp_t e;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    sb.push_back('{name, e1, e2});
    #2;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      cmp({e.name, ".rd1"}, ReadData1, e.e1);
      cmp({e.name, ".rd2"}, ReadData2, e.e2);
    end
  endtask

  task automatic wr(input regidx_t a, input word_t d);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    tick();
    RegWrite      = 1'b0;
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < NUM_REGS; i++) begin
      rd(name, regidx_t'(i), regidx_t'(NUM_REGS-1-i), model[i], model[NUM_REGS-1-i]);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd0,  64'h0, 64'h0};
    vecs[1] = '{1'b0, 5'd0,  64'h0, 5'd31, 5'd15, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{1'b1, 5'd7,  64'hA5A5_A5A5_A5A5_A5A5, 5'd1, 5'd2,
                64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    vecs[3] = '{1'b0, 5'd7,  64'h0, 5'd7, 5'd7, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5};
    vecs[4] = '{1'b0, 5'd3,  64'h0, 5'd7, 5'd3, 64'hA5A5_A5A5_A5A5_A5A5, 64'h3333_3333_3333_3333};
    vecs[5] = '{1'b1, 5'd12, 64'h0123_4567_89AB_CDEF, 5'd11, 5'd13,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hDDDD_DDDD_DDDD_DDDD};
    vecs[6] = '{1'b0, 5'd0,  64'h0, 5'd12, 5'd31, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[7] = '{1'b1, 5'd0,  64'h5A, 5'd30, 5'd29, 64'hFFFF_FFFF_FFFF_FFFE, 64'hEEEE_EEEE_EEEE_EEED};
    vecs[8] = '{1'b0, 5'd0,  64'h0, 5'd0, 5'd14, 64'h5A, 64'hEEEE_EEEE_EEEE_EEEE};

    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    check_all("reset_state");

    wr(5'd5, 64'hDEAD_BEEF_0123_4567);
    rd("x5_written", 5'd5, 5'd5, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    reset = 1'b1; tick(); reset = 1'b0;
    rd("x5_after_reset", 5'd5, 5'd5, 64'h0, 64'h0);

    for (int i = 0; i < NUM_REGS-1; i++) begin
      model[i] = K * i;
      wr(regidx_t'(i), model[i]);
    end
    check_all("sweep");

    for (int v = 0; v < 9; v++) begin
      RegWrite      = vecs[v].rw;
      WriteRegister = vecs[v].wa;
      WriteData     = vecs[v].wd;
      rd($sformatf("vec%0d", v), vecs[v].ra1, vecs[v].ra2, vecs[v].e1, vecs[v].e2);
      if (vecs[v].rw && vecs[v].wa != XZR_IDX) model[vecs[v].wa] = vecs[v].wd;
      tick();
    end
    RegWrite = 1'b0;
    check_all("after_vectors");

    // Reset beats a simultaneous write; first write after release is accepted.
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h1234;
    tick();
    reset = 1'b0; WriteRegister = 5'd4; WriteData = 64'h44;
    rd("reset_beats_write", 5'd3, 5'd7, 64'h0, 64'h0);
    tick();
    RegWrite = 1'b0;
    rd("first_write_after_reset", 5'd4, 5'd3, 64'h44, 64'h0);
    tick();

    // Same-cycle read of the write target.
    wr(5'd9, 64'h1);
    RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h2;
    rd("same_cycle", 5'd9, 5'd9, BYP ? 64'h2 : 64'h1, BYP ? 64'h2 : 64'h1);
    tick();
    RegWrite = 1'b0;
    rd("after_edge", 5'd9, 5'd4, 64'h2, 64'h44);

    // Bypass is suppressed while reset is high; unknown enable cannot corrupt reset.
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h3;
    rd("bypass_under_reset", 5'd9, 5'd0, 64'h2, 64'h0);
    tick();
    RegWrite = 1'bx; WriteRegister = 5'd9; WriteData = 64'hFFFF;
    tick();
    reset = 1'b0; RegWrite = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    check_all("x_enable_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
